decision_sequencer: RTL
=======================

Name: decision_sequencer

Overview:
- Control block that sequences a test-pattern decision indicator configured for serial-to-simultaneous buffering (one test pattern evaluated per cycle).
- Counts incoming test-pattern results and drives the indicator's enable and shift-enable.
- Captures the parallel indicator vector once all test patterns are in, then selects the lowest-index correctable test pattern.
- Presents the selection downstream with a valid/ready handshake; sits between the per-TP syndrome/degree pipeline and the codeword-correction mux.

Parameters:
TP_NUMS, 8, number of test patterns per codeword (>=2)
TP_IDX_WIDTH, 3, width of test-pattern index; must satisfy 2**TP_IDX_WIDTH >= TP_NUMS

Ports:
clk  input  1  clock
in_ctr_Arst  input  1  asynchronous active-high reset
in_start  input  1  pulse: begin a new codeword decision
in_abort  input  1  synchronous abort; return to IDLE
in_tp_valid  input  1  one TP's degree/errCnt is on the indicator inputs this cycle
out_ind_en  output  1  drives indicator in_ctr_en
out_ind_shEn  output  1  drives indicator in_ctr_shEnOutBuf
out_ind_Srst  output  1  drives indicator in_ctr_Srst
in_indicTP  input  TP_NUMS  parallel indicator vector; bit i = TP i correctable
out_busy  output  1  high in any state except IDLE
out_tp_cnt  output  TP_IDX_WIDTH  TPs accepted so far in current codeword
out_sel_valid  output  1  selection result valid
in_sel_ready  input  1  downstream accepts result
out_sel_idx  output  TP_IDX_WIDTH  selected TP index
out_sel_fail  output  1  no TP correctable

Behaviour:
- Reset (async, in_ctr_Arst=1): state=IDLE; all outputs 0; internal capture register r_ind=0.
- States: IDLE, CLR, COLLECT, SETTLE, DECIDE, OUT.
- IDLE: in_start=1 -> CLR. Otherwise stay.
- CLR (1 cycle): out_ind_Srst=1, out_ind_en=1; out_tp_cnt<=0 -> COLLECT.
- COLLECT: out_ind_en=1; out_ind_shEn=in_tp_valid (combinational). Each in_tp_valid increments out_tp_cnt. in_tp_valid with out_tp_cnt==TP_NUMS-1 -> SETTLE; out_tp_cnt then wraps to 0. in_tp_valid low: hold, no shift; gaps of any length allowed.
- SETTLE (1 cycle): out_ind_en=0; lets the indicator's last shift propagate -> DECIDE.
- DECIDE (1 cycle): r_ind<=in_indicTP. out_sel_idx<=lowest i with in_indicTP[i]=1. out_sel_fail<=(in_indicTP==0). If fail, out_sel_idx<=0. -> OUT.
- OUT: out_sel_valid=1; out_sel_idx and out_sel_fail held stable. in_sel_ready=1 completes the handshake. If in_start is also 1 in that cycle -> CLR (back-to-back); otherwise -> IDLE. out_sel_valid drops the cycle after the handshake.
- Latency: in_tp_valid for the last TP at cycle T -> out_sel_valid=1 at T+3 (T+1 SETTLE, T+2 DECIDE, T+3 OUT).
- in_start outside IDLE, and outside the OUT handshake cycle: ignored.
- in_tp_valid outside COLLECT: ignored; no shift, no count.
- in_abort=1 in any state: next state IDLE; out_sel_valid, out_ind_en and out_ind_shEn deasserted next cycle; out_tp_cnt<=0. in_abort has priority over in_start and over the handshake.
- Async reset mid-operation: immediate return to reset values; no partial result emitted.
- out_ind_shEn is never 1 while out_ind_en is 0.

Test Plan:
- Nominal: TP_NUMS=8, start, 8 consecutive in_tp_valid, in_indicTP=8'b0010_1000 -> at T+3 out_sel_valid=1, out_sel_idx=3, out_sel_fail=0; ready=1 -> IDLE, out_busy=0.
- No correctable TP: in_indicTP=8'h00 -> out_sel_fail=1, out_sel_idx=0; held 5 cycles with ready=0, values stable.
- Gapped input: in_tp_valid on alternating cycles -> out_tp_cnt steps 0..7 only on valid cycles; out_ind_shEn pulses exactly 8 times; in_indicTP=8'h80 -> idx=7.
- Back-to-back: in_start coincident with the OUT handshake -> CLR next cycle with out_ind_Srst=1; second codeword with in_indicTP=8'h01 -> idx=0.
- Abort: in_abort after 4 TPs -> IDLE next cycle, out_tp_cnt=0, no out_sel_valid; a new start then needs a full 8 TPs.
- Async reset asserted in OUT -> all outputs 0 immediately, state IDLE; extra in_tp_valid and in_start while busy are ignored.

Source files
------------

// File: rtl/decision_sequencer.sv
// Sequences the test-pattern decision indicator: clears it, streams one TP per valid
// cycle, captures the parallel correctable vector and hands off the lowest correctable TP.
module decision_sequencer #(
    parameter int TP_NUMS      = 8,
    parameter int TP_IDX_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    in_ctr_Arst,
    input  logic                    in_start,
    input  logic                    in_abort,
    input  logic                    in_tp_valid,
    output logic                    out_ind_en,
    output logic                    out_ind_shEn,
    output logic                    out_ind_Srst,
    input  logic [TP_NUMS-1:0]      in_indicTP,
    output logic                    out_busy,
    output logic [TP_IDX_WIDTH-1:0] out_tp_cnt,
    output logic                    out_sel_valid,
    input  logic                    in_sel_ready,
    output logic [TP_IDX_WIDTH-1:0] out_sel_idx,
    output logic                    out_sel_fail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_COLLECT,
        S_SETTLE,
        S_DECIDE,
        S_OUT
    } state_e;

    state_e                    state_q, state_d;
    logic [TP_IDX_WIDTH-1:0]   cnt_q, cnt_d;
    logic [TP_NUMS-1:0]        r_ind_q, r_ind_d;
    logic                      fail_q, fail_d;

    // Lowest set bit wins; an all-zero vector maps to index 0.
    function automatic logic [TP_IDX_WIDTH-1:0] first_set(input logic [TP_NUMS-1:0] v);
        logic [TP_IDX_WIDTH-1:0] r;
        r = '0;
        for (int i = TP_NUMS - 1; i >= 0; i--) begin
            if (v[i]) r = TP_IDX_WIDTH'(i);
        end
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_ind_d = r_ind_q;
        fail_d  = fail_q;
        if (in_abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_start) state_d = S_CLR;
                end
                S_CLR: begin
                    cnt_d   = '0;
                    state_d = S_COLLECT;
                end
                S_COLLECT: begin
                    if (in_tp_valid) begin
                        if (cnt_q == TP_IDX_WIDTH'(TP_NUMS - 1)) begin
                            cnt_d   = '0;
                            state_d = S_SETTLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    state_d = S_DECIDE;
                end
                S_DECIDE: begin
                    r_ind_d = in_indicTP;
                    fail_d  = (in_indicTP == '0);
                    state_d = S_OUT;
                end
                S_OUT: begin
                    if (in_sel_ready) state_d = in_start ? S_CLR : S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge in_ctr_Arst) begin
        if (in_ctr_Arst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            r_ind_q <= '0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_ind_q <= r_ind_d;
            fail_q  <= fail_d;
        end
    end

    // Indicator controls decode straight from the state register; shift follows the live valid.
    assign out_ind_Srst  = (state_q == S_CLR);
    assign out_ind_en    = (state_q == S_CLR) || (state_q == S_COLLECT);
    assign out_ind_shEn  = (state_q == S_COLLECT) && in_tp_valid;
    assign out_busy      = (state_q != S_IDLE);
    assign out_sel_valid = (state_q == S_OUT);
    assign out_tp_cnt    = cnt_q;
    assign out_sel_idx   = first_set(r_ind_q);
    assign out_sel_fail  = fail_q;

endmodule
